// File: rtl/mem_model_pkg.sv
// mem_model_pkg: small helpers shared by the behavioural memory model files.
package mem_model_pkg;
    function automatic int unsigned ptr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/mem_model_resp_fifo.sv
// mem_model_resp_fifo: synchronous FIFO holding read responses in acceptance order.
module mem_model_resp_fifo
    import mem_model_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic do_push, do_pop;
    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    always_comb begin
        full = count_q == CW'(DEPTH);
        empty = count_q == '0;
        head = mem_q[rd_ptr_q];
        do_push = push && !full;
        do_pop = pop && !empty;
        wr_ptr_d = do_push ? next_ptr(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = do_pop ? next_ptr(rd_ptr_q) : rd_ptr_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end
endmodule

// File: rtl/mem_model.sv
// mem_model: cycle-accurate memory with real storage, fixed-latency tagged reads
// and a single-slot write acknowledge, on independent valid/ready channels.
module mem_model
    import mem_model_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH_LOG2 = 10,
    parameter int READ_LATENCY = 2,
    parameter int RESP_DEPTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ_RECEIVE_VALID,
    input  logic [ADDR_WIDTH-1:0] READ_RECEIVE_ADDR,
    input  logic [DATA_WIDTH-1:0] READ_RECEIVE_TAG,
    output logic                  READ_RECEIVE_READY,
    output logic                  READ_SEND_VALID,
    output logic [ADDR_WIDTH-1:0] READ_SEND_ADDR,
    output logic [DATA_WIDTH-1:0] READ_SEND_DATA,
    output logic [DATA_WIDTH-1:0] READ_SEND_TAG,
    input  logic                  READ_SEND_READY,
    input  logic                  WRITE_RECEIVE_VALID,
    input  logic [ADDR_WIDTH-1:0] WRITE_RECEIVE_ADDR,
    input  logic [DATA_WIDTH-1:0] WRITE_RECEIVE_DATA,
    output logic                  WRITE_RECEIVE_READY,
    output logic                  WRITE_SEND_VALID,
    output logic [ADDR_WIDTH-1:0] WRITE_SEND_ADDR,
    input  logic                  WRITE_SEND_READY
);
    localparam int CW = $clog2(RESP_DEPTH + 1);
    localparam int PL = (READ_LATENCY > 1) ? READ_LATENCY - 1 : 1;
    localparam int EW = ADDR_WIDTH + 2 * DATA_WIDTH;
    typedef struct packed {
        logic                  v;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [DATA_WIDTH-1:0] tag;
    } stage_t;
    // Storage is preset once at time zero and deliberately survives RST.
    logic [DATA_WIDTH-1:0] mem_q [2**DEPTH_LOG2] = '{default: INIT_VALUE};
    stage_t in_s, out_s;
    stage_t pipe_q [PL];
    stage_t pipe_d [PL];
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic wack_v_q, wack_v_d;
    logic [ADDR_WIDTH-1:0] wack_addr_q, wack_addr_d;
    logic rd_acc, wr_acc, rd_pop, fifo_full, fifo_empty;
    logic [EW-1:0] fifo_head;
    always_comb begin
        READ_RECEIVE_READY = !RST && (outstanding_q < CW'(RESP_DEPTH));
        WRITE_RECEIVE_READY = !RST && (!wack_v_q || WRITE_SEND_READY);
        READ_SEND_VALID = !RST && !fifo_empty;
        WRITE_SEND_VALID = !RST && wack_v_q;
        WRITE_SEND_ADDR = wack_addr_q;
        {READ_SEND_ADDR, READ_SEND_DATA, READ_SEND_TAG} = fifo_head;
        rd_acc = READ_RECEIVE_VALID && READ_RECEIVE_READY;
        wr_acc = WRITE_RECEIVE_VALID && WRITE_RECEIVE_READY;
        rd_pop = READ_SEND_VALID && READ_SEND_READY;
        in_s = '{v: rd_acc, addr: READ_RECEIVE_ADDR, tag: READ_RECEIVE_TAG,
                 data: mem_q[READ_RECEIVE_ADDR[DEPTH_LOG2-1:0]]};
        pipe_d[0] = in_s;
        for (int i = 1; i < PL; i++) pipe_d[i] = pipe_q[i-1];
        // The FIFO write itself is the last latency stage.
        out_s = (READ_LATENCY > 1) ? pipe_q[PL-1] : in_s;
        outstanding_d = outstanding_q + CW'(rd_acc) - CW'(rd_pop);
        wack_v_d = wr_acc || (wack_v_q && !WRITE_SEND_READY);
        wack_addr_d = wr_acc ? WRITE_RECEIVE_ADDR : wack_addr_q;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < PL; i++) pipe_q[i] <= '0;
            outstanding_q <= '0;
            wack_v_q <= 1'b0;
        end else begin
            for (int i = 0; i < PL; i++) pipe_q[i] <= pipe_d[i];
            outstanding_q <= outstanding_d;
            wack_v_q <= wack_v_d;
        end
        wack_addr_q <= wack_addr_d;
        if (!RST) assert (!(fifo_full && out_s.v));
    end
    always_ff @(posedge CLK) begin
        if (wr_acc) mem_q[WRITE_RECEIVE_ADDR[DEPTH_LOG2-1:0]] <= WRITE_RECEIVE_DATA;
    end
    mem_model_resp_fifo #(.WIDTH(EW), .DEPTH(RESP_DEPTH)) u_resp_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (out_s.v),
        .push_data({out_s.addr, out_s.data, out_s.tag}),
        .pop      (rd_pop),
        .head     (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );
endmodule
